// File: rtl/hdmi_ctrl_pkg.sv
// Shared types and constants for the HDMI output control path.
package hdmi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOCK    = 3'd0,
        ST_TXRST   = 3'd1,
        ST_WAIT_VS = 3'd2,
        ST_RUN     = 3'd3,
        ST_ARM     = 3'd4,
        ST_BLANK   = 3'd5
    } state_e;

    localparam int unsigned SRC_COLORBAR = 0;
    localparam int unsigned SRC_SOBEL    = 1;

    localparam logic [23:0] BLANK_RGB = 24'h000000;

    // Width of a counter that must hold values 0..maxval (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval <= 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/lock_qualify.sv
// Synchronizes the MMCM lock and qualifies it after LOCK_CYCLES consecutive high cycles.
module lock_qualify
    import hdmi_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic lock_async,
    output logic lock_sync,
    output logic lock_ok
);

    localparam int unsigned CW = cnt_width(LOCK_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CYCLES);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating run-length of synced-lock high cycles; any low cycle clears it.
    always_comb begin
        cnt_d = '0;
        if (sync_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= lock_async;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_sync = sync_q;
    assign lock_ok   = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hdmi_src_sched.sv
// Start-up sequencer and frame-synchronous pixel-source scheduler for the HDMI path.
module hdmi_src_sched
    import hdmi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned SRC_W         = 1,
    parameter int unsigned DEFAULT_SRC   = 0,
    parameter int unsigned LOCK_CYCLES   = 1024,
    parameter int unsigned TX_RST_CYCLES = 16,
    parameter int unsigned BLANK_FRAMES  = 1
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             clk_locked,
    input  logic             frame_start,
    input  logic             src_req,
    input  logic [SRC_W-1:0] src_req_id,
    output logic             src_req_ack,
    output logic             src_req_err,
    output logic             busy,
    output logic             tx_rst_n,
    output logic             video_en,
    output logic             blank,
    output logic [SRC_W-1:0] src_sel,
    output logic [15:0]      frame_cnt,
    output logic [2:0]       state
);

    localparam int unsigned TW = cnt_width(TX_RST_CYCLES);
    localparam int unsigned BW = cnt_width(BLANK_FRAMES);
    localparam logic [TW-1:0] TXC_LAST = TW'(TX_RST_CYCLES - 1);
    localparam logic [BW-1:0] BC_LAST  = BW'(BLANK_FRAMES - 1);

    logic lock_sync;
    logic lock_ok;
    logic lost;

    state_e           st_q, st_d;
    logic [TW-1:0]    txc_q, txc_d;
    logic [BW-1:0]    bc_q, bc_d;
    logic [SRC_W-1:0] pend_q, pend_d;
    logic [SRC_W-1:0] sel_q, sel_d;
    logic             txn_q, txn_d;
    logic             ven_q, ven_d;
    logic             blank_q, blank_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [15:0]      fcnt_q, fcnt_d;

    lock_qualify #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_qualify (
        .clk        (pixel_clk),
        .reset      (reset),
        .lock_async (clk_locked),
        .lock_sync  (lock_sync),
        .lock_ok    (lock_ok)
    );

    always_comb begin
        st_d    = st_q;
        txc_d   = txc_q;
        bc_d    = bc_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        txn_d   = txn_q;
        ven_d   = ven_q;
        blank_d = blank_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
        lost    = (st_q != ST_LOCK) && !lock_sync;

        if (frame_start && ven_q && !lost) begin
            fcnt_d = fcnt_q + 16'd1;
        end

        // Lock loss overrides everything; the selected source survives, the pending one does not.
        if (lost) begin
            st_d    = ST_LOCK;
            txn_d   = 1'b0;
            ven_d   = 1'b0;
            blank_d = 1'b1;
            pend_d  = '0;
        end else begin
            case (st_q)
                ST_LOCK: begin
                    if (lock_ok) begin
                        st_d  = ST_TXRST;
                        txc_d = '0;
                    end
                end
                ST_TXRST: begin
                    if (txc_q == TXC_LAST) begin
                        txn_d = 1'b1;
                        st_d  = ST_WAIT_VS;
                    end else begin
                        txc_d = txc_q + TW'(1);
                    end
                end
                ST_WAIT_VS: begin
                    if (frame_start) begin
                        ven_d   = 1'b1;
                        blank_d = 1'b0;
                        st_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (src_req) begin
                        if (32'(src_req_id) >= NUM_SRC) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                            if (src_req_id != sel_q) begin
                                pend_d = src_req_id;
                                st_d   = ST_ARM;
                            end
                        end
                    end
                end
                ST_ARM: begin
                    if (frame_start) begin
                        blank_d = 1'b1;
                        bc_d    = '0;
                        st_d    = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (frame_start) begin
                        if (bc_q == BC_LAST) begin
                            sel_d   = pend_q;
                            blank_d = 1'b0;
                            st_d    = ST_RUN;
                        end else begin
                            bc_d = bc_q + BW'(1);
                        end
                    end
                end
                default: st_d = ST_LOCK;
            endcase
        end

        busy_d = (st_d != ST_RUN);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            st_q    <= ST_LOCK;
            txc_q   <= '0;
            bc_q    <= '0;
            pend_q  <= '0;
            sel_q   <= SRC_W'(DEFAULT_SRC);
            txn_q   <= 1'b0;
            ven_q   <= 1'b0;
            blank_q <= 1'b1;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            txc_q   <= txc_d;
            bc_q    <= bc_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            txn_q   <= txn_d;
            ven_q   <= ven_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign src_req_ack = ack_q;
    assign src_req_err = err_q;
    assign busy        = busy_q;
    assign tx_rst_n    = txn_q;
    assign video_en    = ven_q;
    assign blank       = blank_q;
    assign src_sel     = sel_q;
    assign frame_cnt   = fcnt_q;
    assign state       = st_q;

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Scoreboard bench for hdmi_src_sched: a behavioural model queues expected outputs per edge.
module tb_hdmi_src_sched;

    localparam int NUM_SRC = 2;
    localparam int SRC_W   = 2;
    localparam int DEF_SRC = 0;
    localparam int LC      = 8;
    localparam int TXC     = 4;
    localparam int BF      = 2;

    logic             pixel_clk = 1'b0;
    logic             reset;
    logic             clk_locked;
    logic             frame_start;
    logic             src_req;
    logic [SRC_W-1:0] src_req_id;
    logic             src_req_ack;
    logic             src_req_err;
    logic             busy;
    logic             tx_rst_n;
    logic             video_en;
    logic             blank;
    logic [SRC_W-1:0] src_sel;
    logic [15:0]      frame_cnt;
    logic [2:0]       state;

    always #5 pixel_clk = ~pixel_clk;

    hdmi_src_sched #(
        .NUM_SRC       (NUM_SRC),
        .SRC_W         (SRC_W),
        .DEFAULT_SRC   (DEF_SRC),
        .LOCK_CYCLES   (LC),
        .TX_RST_CYCLES (TXC),
        .BLANK_FRAMES  (BF)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .clk_locked  (clk_locked),
        .frame_start (frame_start),
        .src_req     (src_req),
        .src_req_id  (src_req_id),
        .src_req_ack (src_req_ack),
        .src_req_err (src_req_err),
        .busy        (busy),
        .tx_rst_n    (tx_rst_n),
        .video_en    (video_en),
        .blank       (blank),
        .src_sel     (src_sel),
        .frame_cnt   (frame_cnt),
        .state       (state)
    );

    typedef struct packed {
        logic        txn;
        logic        ven;
        logic        blank;
        logic        busy;
        logic        ack;
        logic        err;
        logic [1:0]  sel;
        logic [15:0] fcnt;
        logic [2:0]  st;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: phases named by their state codes, lock judged from raw sample history.
    int   ph;
    bit   hist[$];
    int   edge_n;
    int   tx_entry;
    int   bseen;
    int   pend;
    obs_t m;

    function automatic void model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        ph      = 0;
        pend    = 0;
        m.txn   = 1'b0;
        m.ven   = 1'b0;
        m.blank = 1'b1;
        m.busy  = 1'b1;
        m.ack   = 1'b0;
        m.err   = 1'b0;
        m.sel   = 2'(DEF_SRC);
        m.fcnt  = 16'd0;
        m.st    = 3'd0;
    endfunction

    function automatic void model_step(bit rst, bit lk, bit fs, bit rq, int rid);
        bit sync_now;
        bit loss;
        int run;
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        m.ack = 1'b0;
        m.err = 1'b0;
        // Logic at this edge sees the sample from two edges back; the qualifier run ends one earlier.
        sync_now = hist[hist.size() - 2];
        run = 0;
        for (int i = hist.size() - 3; i >= 0; i--) begin
            if (!hist[i]) break;
            run++;
        end
        hist.push_back(lk);
        if (hist.size() > LC + 8) void'(hist.pop_front());

        loss = (ph != 0) && !sync_now;
        if (fs && m.ven && !loss) m.fcnt = m.fcnt + 16'd1;

        if (loss) begin
            ph      = 0;
            m.txn   = 1'b0;
            m.ven   = 1'b0;
            m.blank = 1'b1;
        end else begin
            case (ph)
                0: if (run >= LC) begin ph = 1; tx_entry = edge_n; end
                1: if (edge_n - tx_entry == TXC) begin m.txn = 1'b1; ph = 2; end
                2: if (fs) begin m.ven = 1'b1; m.blank = 1'b0; ph = 3; end
                3: if (rq) begin
                       if (rid >= NUM_SRC) m.err = 1'b1;
                       else begin
                           m.ack = 1'b1;
                           if (rid != int'(m.sel)) begin pend = rid; ph = 4; end
                       end
                   end
                4: if (fs) begin m.blank = 1'b1; bseen = 0; ph = 5; end
                5: if (fs) begin
                       bseen++;
                       if (bseen == BF) begin m.sel = 2'(pend); m.blank = 1'b0; ph = 3; end
                   end
                default: ph = 0;
            endcase
        end
        m.busy = (ph != 3);
        m.st   = 3'(ph);
    endfunction

    task automatic step(bit rst, bit lk, bit fs, bit rq, int rid);
        reset       = rst;
        clk_locked  = lk;
        frame_start = fs;
        src_req     = rq;
        src_req_id  = 2'(rid);
        @(posedge pixel_clk);
        model_step(rst, lk, fs, rq, rid);
        exp_q.push_back(m);
        #1;
    endtask

    // Drives lock high with sporadic frame starts until the model reaches RUN.
    task automatic wait_run(int budget);
        int n = 0;
        while (ph != 3 && n < budget) begin
            step(1'b0, 1'b1, ($urandom_range(0, 3) == 0), 1'b0, 0);
            n++;
        end
        checks++;
        if (ph != 3) begin
            errors++;
            $display("FAIL wait_run: phase=%0d after %0d cycles, required phase 3", ph, n);
        end
    endtask

    obs_t act_o;
    obs_t exp_o;
    always @(negedge pixel_clk) begin
        while (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act_o = '{txn: tx_rst_n, ven: video_en, blank: blank, busy: busy,
                      ack: src_req_ack, err: src_req_err, sel: src_sel,
                      fcnt: frame_cnt, st: state};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL outputs t=%0t got txn=%b ven=%b blank=%b busy=%b ack=%b err=%b sel=%0d fcnt=%0d st=%0d required txn=%b ven=%b blank=%b busy=%b ack=%b err=%b sel=%0d fcnt=%0d st=%0d",
                         $time, act_o.txn, act_o.ven, act_o.blank, act_o.busy, act_o.ack, act_o.err,
                         act_o.sel, act_o.fcnt, act_o.st, exp_o.txn, exp_o.ven, exp_o.blank,
                         exp_o.busy, exp_o.ack, exp_o.err, exp_o.sel, exp_o.fcnt, exp_o.st);
            end
        end
    end

    initial begin
        bit lk;
        int drop;
        int other;
        edge_n = 0;
        model_reset();
        reset = 1'b1; clk_locked = 1'b0; frame_start = 1'b0; src_req = 1'b0; src_req_id = '0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_run(200);

        // Switch to 1 with a request ignored mid-blank.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Same-source ack, out-of-range error, then request coinciding with frame_start.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        // Lock loss during BLANK, then full relock.
        other = (int'(m.sel) == 0) ? 1 : 0;
        step(1'b0, 1'b1, 1'b0, 1'b1, other);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_run(200);

        // Randomized traffic with occasional lock drops and resets.
        lk = 1'b1;
        drop = 0;
        for (int c = 0; c < 3000; c++) begin
            if (drop > 0) begin
                drop--;
                lk = (drop == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                drop = $urandom_range(1, 6);
                lk = 1'b0;
            end
            step(($urandom_range(0, 999) == 0), lk, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        // frame_cnt wrap with back-to-back frame starts.
        wait_run(300);
        for (int c = 0; c < 65540; c++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

        @(negedge pixel_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_src_sched.md
# hdmi_src_sched

Start-up sequencer and frame-synchronous source scheduler for the HDMI output path. It qualifies the clock-wizard lock, holds the DVI transmitter in reset, and enables video only on a frame boundary. It also switches the pixel source (colour-bar generator, Sobel edge pipeline, …) on request, blanking whole frames around each switch so no torn frame reaches the sink. It sits in the `pixel_clk` domain between the clock wizard, video driver, source mux and `dvi_transmitter_top`.

## Interface
Parameters:
- `NUM_SRC`, 2 — number of selectable pixel sources.
- `SRC_W`, 1 — width of source index; must satisfy 2^`SRC_W` ≥ `NUM_SRC`.
- `DEFAULT_SRC`, 0 — source selected out of reset.
- `LOCK_CYCLES`, 1024 — consecutive synced-lock cycles required before the transmitter reset is released.
- `TX_RST_CYCLES`, 16 — cycles `tx_rst_n` is held low after lock qualifies.
- `BLANK_FRAMES`, 1 — whole blanked frames inserted per source switch; must be ≥ 1.

Ports:
- `pixel_clk` in 1 — pixel clock; the only clock.
- `reset` in 1 — synchronous, active-high.
- `clk_locked` in 1 — MMCM lock; asynchronous, synchronized internally.
- `frame_start` in 1 — one-cycle pulse on the first cycle of vsync, from the video driver.
- `src_req` in 1 — one-cycle request pulse.
- `src_req_id` in `SRC_W` — requested source; sampled only with `src_req`.
- `src_req_ack` out 1 — one-cycle pulse: request accepted.
- `src_req_err` out 1 — one-cycle pulse: `src_req_id` ≥ `NUM_SRC`.
- `busy` out 1 — high whenever state ≠ RUN; requests are ignored while high.
- `tx_rst_n` out 1 — drives the transmitter `reset_n`.
- `video_en` out 1 — enables the video driver DE/data.
- `blank` out 1 — forces source-mux RGB to 0x000000.
- `src_sel` out `SRC_W` — source-mux select.
- `frame_cnt` out 16 — frame_start count while `video_en` is high; wraps 0xFFFF → 0.
- `state` out 3 — current state encoding.

## Operation
- All outputs are registered.
- Reset values: `tx_rst_n`=0, `video_en`=0, `blank`=1, `busy`=1, `src_sel`=`DEFAULT_SRC`, `src_req_ack`=0, `src_req_err`=0, `frame_cnt`=0, `state`=LOCK.
- LOCK: counts consecutive cycles with synced lock high. Any low cycle clears the count. At `LOCK_CYCLES` → TXRST.
- TXRST: `tx_rst_n`=0 for `TX_RST_CYCLES` cycles, then `tx_rst_n`←1 → WAIT_VS.
- WAIT_VS: on `frame_start`, `video_en`←1 and `blank`←0 → RUN.
- RUN: `busy`=0.
  - `src_req` with id ≥ `NUM_SRC`: `src_req_err` pulse; stay in RUN.
  - `src_req` with id = `src_sel`: ack pulse; stay in RUN; no blanking.
  - Any other `src_req`: ack pulse, latch id as pending → ARM.
- ARM: on the next `frame_start`, `blank`←1, blank count←0 → BLANK. A `frame_start` in the same cycle as the accepted `src_req` does not count.
- BLANK: each `frame_start` increments the blank count. On the `BLANK_FRAMES`-th one, in the same edge: `src_sel`←pending, `blank`←0 → RUN.
- Lock loss (synced lock low) in any state except LOCK, highest priority, next edge:
  - → LOCK with `tx_rst_n`=0, `video_en`=0, `blank`=1.
  - Pending request is discarded; `src_sel` is retained.
  - `frame_cnt` holds its value.
- `reset` mid-operation: all outputs return to reset values on the next edge.
- `src_req` while `busy`=1: no ack, no err, no effect.

## Timing
- `clk_locked` passes through a 2-flop synchronizer.
- Lock rise to state TXRST: 2 + `LOCK_CYCLES` cycles.
- TXRST entry to `tx_rst_n` high: `TX_RST_CYCLES` cycles.
- `src_req` to `src_req_ack`/`src_req_err`: 1 cycle.
- `frame_start` to `blank`/`src_sel`/`video_en` update: 1 cycle.
- Lock loss (synchronizer output) to `tx_rst_n`=0: 1 cycle.

## Structure
- Shared package `hdmi_ctrl_pkg`:
  - state encodings LOCK=0, TXRST=1, WAIT_VS=2, RUN=3, ARM=4, BLANK=5;
  - source IDs SRC_COLORBAR=0, SRC_SOBEL=1;
  - blank RGB constant 24'h000000.
- Sub-module `lock_qualify` contains the synchronizer and the consecutive-cycle counter, and outputs `lock_ok`.

## Test plan
- `LOCK_CYCLES`=8, `TX_RST_CYCLES`=4; raise `clk_locked` at cycle 10 → `tx_rst_n` rises at cycle 24; `video_en` rises 1 cycle after the next `frame_start`.
- In RUN, `src_req` id=1 → ack at +1 cycle, `busy`=1. First `frame_start` → `blank`=1. Second `frame_start` → `src_sel`=1, `blank`=0, `busy`=0.
- `src_req` id=0 while `src_sel`=0 → ack, `blank` stays 0. Id=3 with `SRC_W`=2, `NUM_SRC`=2 → `src_req_err` pulse, no state change.
- `src_req` in the same cycle as `frame_start` → blanking starts at the following `frame_start`, not the current one. `src_req` during BLANK → no ack.
- Drop `clk_locked` during BLANK → `tx_rst_n`=0 and `blank`=1 within 3 cycles; `src_sel` unchanged. On relock the full sequence restarts.
- 65536 frames with video enabled → `frame_cnt` wraps to 0.
